// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FP issue controller: op codes, FSM states, default latencies.
package fpu_ctrl_pkg;

  localparam int unsigned CntW = 8;
  typedef logic [CntW-1:0] lat_t;

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpMul   = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpSqrt  = 4'd4;
  localparam logic [3:0] OpMin   = 4'd5;
  localparam logic [3:0] OpMax   = 4'd6;
  localparam logic [3:0] OpSgnj  = 4'd7;
  localparam logic [3:0] OpCvtFI = 4'd8;
  localparam logic [3:0] OpCvtIF = 4'd9;
  localparam logic [3:0] OpCmp   = 4'd10;
  localparam logic [3:0] OpMvXW  = 4'd11;
  localparam logic [3:0] OpClass = 4'd12;

  localparam int unsigned LatAddDef  = 2;
  localparam int unsigned LatMulDef  = 3;
  localparam int unsigned LatDivDef  = 10;
  localparam int unsigned LatSqrtDef = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } fpu_state_e;

endpackage

// File: rtl/fpu_lat_table.sv
// Combinational op-code to execution-latency lookup; unlisted codes take one cycle.
module fpu_lat_table
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned LAT_ADD  = LatAddDef,
  parameter int unsigned LAT_MUL  = LatMulDef,
  parameter int unsigned LAT_DIV  = LatDivDef,
  parameter int unsigned LAT_SQRT = LatSqrtDef
) (
  input  logic [3:0] op,
  output lat_t       lat
);

  always_comb begin
    case (op)
      OpAdd, OpSub, OpMin, OpMax: lat = lat_t'(LAT_ADD);
      OpMul:                      lat = lat_t'(LAT_MUL);
      OpDiv:                      lat = lat_t'(LAT_DIV);
      OpSqrt:                     lat = lat_t'(LAT_SQRT);
      default:                    lat = lat_t'(1);
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue FP controller: accepts one op, times its execution, arbitrates the
// shared write port against loads, accumulates sticky flags and raises decode stalls.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned LAT_ADD  = LatAddDef,
  parameter int unsigned LAT_MUL  = LatMulDef,
  parameter int unsigned LAT_DIV  = LatDivDef,
  parameter int unsigned LAT_SQRT = LatSqrtDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic        issue_to_int,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic        chk_float,
  output logic [3:0]  fpu_op,
  output logic        fpu_start,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  input  logic        ld_wb_valid,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_to_int,
  output logic [31:0] wb_data,
  input  logic        flush,
  input  logic        fflags_clr,
  output logic [4:0]  fflags,
  output logic        stall
);

  fpu_state_e  state_q, state_d;
  lat_t        cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic        to_int_q;
  logic [31:0] data_q;
  logic [4:0]  flags_q;
  logic [4:0]  fflags_q, fflags_d;
  lat_t        lat;
  logic        accept, capture, complete, x0_dest;

  fpu_lat_table #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT)
  ) u_lat_table (
    .op  (issue_op),
    .lat (lat)
  );

  // Flush wins over a same-cycle accept, capture or write-back.
  assign accept   = (state_q == StIdle) & issue_valid & ~flush;
  assign capture  = (state_q == StExec) & (cnt_q == '0) & ~flush;
  assign complete = (state_q == StWb) & ~ld_wb_valid & ~flush;
  assign x0_dest  = to_int_q & (rd_q == 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue_valid) begin
          state_d = StExec;
          cnt_d   = lat - lat_t'(1);
          first_d = 1'b1;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - lat_t'(1);
        end
      end
      StWb: begin
        if (!ld_wb_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      first_d = 1'b0;
    end
  end

  always_comb begin
    issue_ready = (state_q == StIdle);
    fpu_start   = (state_q == StExec) & first_q;
    wb_valid    = complete & ~x0_dest;
    // An x0 integer destination is never written, so it cannot be a hazard.
    stall       = ((state_q != StIdle) & (chk_float == ~to_int_q) &
                   ((chk_rs1 == rd_q) | (chk_rs2 == rd_q)) & ~x0_dest) |
                  (issue_valid & (state_q != StIdle));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      to_int_q <= 1'b0;
      data_q   <= '0;
      flags_q  <= '0;
      fflags_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= issue_op;
        rd_q     <= issue_rd;
        to_int_q <= issue_to_int;
      end
      if (capture) begin
        data_q  <= fpu_result;
        flags_q <= fpu_flags;
      end
      fflags_q <= fflags_d;
    end
  end

  always_comb begin
    fflags_d = fflags_clr ? 5'd0 : fflags_q;
    if (complete) begin
      fflags_d = fflags_d | flags_q;
    end
  end

  assign fpu_op    = op_q;
  assign wb_rd     = rd_q;
  assign wb_to_int = to_int_q;
  assign wb_data   = data_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized and directed bench for fpu_issue_ctrl against a phase-counting reference model.
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op;
  logic [4:0]  issue_rd;
  logic        issue_to_int;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        chk_float;
  logic [3:0]  fpu_op;
  logic        fpu_start;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        ld_wb_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_to_int;
  logic [31:0] wb_data;
  logic        flush, fflags_clr;
  logic [4:0]  fflags;
  logic        stall;

  always #5 clk = ~clk;

  fpu_issue_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_to_int (issue_to_int),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .chk_float    (chk_float),
    .fpu_op       (fpu_op),
    .fpu_start    (fpu_start),
    .fpu_result   (fpu_result),
    .fpu_flags    (fpu_flags),
    .ld_wb_valid  (ld_wb_valid),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_to_int    (wb_to_int),
    .wb_data      (wb_data),
    .flush        (flush),
    .fflags_clr   (fflags_clr),
    .fflags       (fflags),
    .stall        (stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles of execution still owed, plus a pending-write flag.
  int          exec_left;
  bit          first_m, in_wb;
  logic [3:0]  m_op;
  logic [4:0]  m_rd, m_flags, m_ff;
  logic        m_toint;
  logic [31:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_lat(input logic [3:0] op);
    case (op)
      OpAdd, OpSub, OpMin, OpMax: return 2;
      OpMul:                      return 3;
      OpDiv:                      return 10;
      OpSqrt:                     return 12;
      default:                    return 1;
    endcase
  endfunction

  task automatic model_reset();
    exec_left = 0; first_m = 0; in_wb = 0;
    m_op = '0; m_rd = '0; m_flags = '0; m_ff = '0; m_toint = 0; m_data = '0;
  endtask

  task automatic settle();
    bit busy, x0, write, hazard;
    if (!reset) model_reset();
    #1;
    busy   = (exec_left > 0) || in_wb;
    x0     = m_toint && (m_rd == 5'd0);
    write  = in_wb && !ld_wb_valid && !flush;
    hazard = busy && (chk_float == !m_toint) && ((chk_rs1 == m_rd) || (chk_rs2 == m_rd)) && !x0;
    check_eq("issue_ready", issue_ready, !busy);
    check_eq("fpu_op", fpu_op, m_op);
    check_eq("fpu_start", fpu_start, (exec_left > 0) && first_m);
    check_eq("wb_valid", wb_valid, write && !x0);
    check_eq("wb_rd", wb_rd, m_rd);
    check_eq("wb_to_int", wb_to_int, m_toint);
    check_eq("wb_data", wb_data, m_data);
    check_eq("fflags", fflags, m_ff);
    check_eq("stall", stall, hazard || (issue_valid && busy));
  endtask

  task automatic model_edge();
    bit write;
    write = in_wb && !ld_wb_valid && !flush;
    m_ff  = (fflags_clr ? 5'd0 : m_ff) | (write ? m_flags : 5'd0);
    if (flush) begin
      exec_left = 0; in_wb = 0; first_m = 0;
    end else if (exec_left > 0) begin
      first_m = 0;
      if (exec_left == 1) begin
        m_data = fpu_result; m_flags = fpu_flags; in_wb = 1;
      end
      exec_left--;
    end else if (in_wb) begin
      if (!ld_wb_valid) in_wb = 0;
    end else if (issue_valid) begin
      m_op = issue_op; m_rd = issue_rd; m_toint = issue_to_int;
      exec_left = ref_lat(issue_op); first_m = 1;
    end
  endtask

  task automatic advance();
    if (reset) model_edge();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic defaults();
    issue_valid = 0; issue_op = '0; issue_rd = '0; issue_to_int = 0;
    chk_rs1 = 5'd31; chk_rs2 = 5'd31; chk_float = 0;
    ld_wb_valid = 0; flush = 0; fflags_clr = 0;
    fpu_result = $urandom; fpu_flags = '0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic to_int,
                        input logic [4:0] flags, input logic [31:0] data, input logic clr_wb);
    int lat;
    lat = ref_lat(op);
    defaults();
    issue_valid = 1; issue_op = op; issue_rd = rd; issue_to_int = to_int;
    tick();
    for (int i = 1; i <= lat; i++) begin
      defaults();
      fpu_result = (i == lat) ? data : $urandom;
      fpu_flags  = (i == lat) ? flags : 5'($urandom);
      tick();
    end
    defaults();
    fflags_clr = clr_wb;
    settle();
    check_eq("wr_valid", wb_valid, !(to_int && rd == 5'd0));
    check_eq("wr_busy", issue_ready, 0);
    if (!(to_int && rd == 5'd0)) check_eq("wr_data", wb_data, data);
    advance();
    defaults();
  endtask

  initial begin
    model_reset();
    defaults();
    reset = 0;
    @(negedge clk);
    tick();
    tick();
    reset = 1;
    settle();
    check_eq("rst_ready", issue_ready, 1);
    check_eq("rst_fflags", fflags, 0);
    advance();

    // ADD timing: start at T+1, write at T+3 with the T+2 result
    defaults();
    issue_valid = 1; issue_op = OpAdd; issue_rd = 5'd1;
    tick();
    defaults(); fpu_result = 32'h0000_000a;
    settle(); check_eq("add_start", fpu_start, 1); advance();
    fpu_result = 32'h1234_5678;
    settle(); check_eq("add_nowb", wb_valid, 0); advance();
    fpu_result = 32'h0000_dead;
    settle(); check_eq("add_wb", wb_valid, 1); check_eq("add_data", wb_data, 32'h1234_5678);
    advance();
    settle(); check_eq("add_ready", issue_ready, 1); advance();

    // DIV with the load holding the write port for three cycles
    defaults();
    issue_valid = 1; issue_op = OpDiv; issue_rd = 5'd2;
    tick();
    for (int i = 1; i <= 10; i++) begin
      defaults(); fpu_result = (i == 10) ? 32'h0000_cafe : 32'(i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      defaults(); ld_wb_valid = 1; chk_rs1 = 5'd2; chk_float = 1;
      settle(); check_eq("div_ld_wb", wb_valid, 0); check_eq("div_ld_stall", stall, 1);
      advance();
    end
    defaults();
    settle(); check_eq("div_wb", wb_valid, 1); check_eq("div_data", wb_data, 32'h0000_cafe);
    advance();

    // Sticky flag accumulation and clear on completion
    defaults(); fflags_clr = 1; tick();
    run_op(OpMul, 5'd5, 0, 5'b00001, 32'h1111_0000, 0);
    run_op(OpAdd, 5'd6, 0, 5'b00100, 32'h2222_0000, 0);
    settle(); check_eq("ff_or", fflags, 5'b00101); advance();
    run_op(OpMul, 5'd5, 0, 5'b00001, 32'h3333_0000, 0);
    run_op(OpAdd, 5'd6, 0, 5'b00100, 32'h4444_0000, 1);
    settle(); check_eq("ff_clr_cmp", fflags, 5'b00100); advance();

    // SQRT RAW hazard on f3
    defaults();
    issue_valid = 1; issue_op = OpSqrt; issue_rd = 5'd3;
    tick();
    for (int i = 1; i <= 12; i++) begin
      defaults(); chk_rs2 = 5'd3; chk_float = (i != 6);
      settle(); check_eq("sqrt_stall", stall, (i != 6)); advance();
    end
    defaults(); chk_rs2 = 5'd3; chk_float = 1;
    settle(); check_eq("sqrt_wr_stall", stall, 1); check_eq("sqrt_wb", wb_valid, 1); advance();
    defaults(); chk_rs2 = 5'd3; chk_float = 1;
    settle(); check_eq("sqrt_idle_stall", stall, 0); advance();

    // Flush in the 5th DIV cycle
    defaults();
    issue_valid = 1; issue_op = OpDiv; issue_rd = 5'd4;
    tick();
    for (int i = 1; i <= 5; i++) begin
      defaults(); fpu_flags = 5'b11111; flush = (i == 5);
      tick();
    end
    defaults();
    settle();
    check_eq("flush_ready", issue_ready, 1);
    check_eq("flush_wb", wb_valid, 0);
    check_eq("flush_ff", fflags, 5'b00100);
    advance();
    for (int i = 0; i < 12; i++) tick();

    // Reset pulse in the first EXEC cycle
    defaults();
    issue_valid = 1; issue_op = OpMul; issue_rd = 5'd7; issue_to_int = 1;
    tick();
    defaults(); reset = 0;
    settle();
    check_eq("rst_start", fpu_start, 0);
    check_eq("rst_op", fpu_op, 0);
    check_eq("rst_ff", fflags, 0);
    check_eq("rst_wb", wb_valid, 0);
    check_eq("rst_wbrd", wb_rd, 0);
    advance();
    reset = 1;
    for (int i = 0; i < 5; i++) tick();

    // FCVT to x0: no write, NX still accumulates
    defaults(); fflags_clr = 1; tick();
    run_op(OpCvtFI, 5'd0, 1, 5'b00001, 32'h5555_5555, 0);
    settle(); check_eq("x0_ff", fflags, 5'b00001); check_eq("x0_ready", issue_ready, 1);
    advance();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 299) != 0);
      issue_valid  = $urandom_range(0, 1);
      issue_op     = 4'($urandom_range(0, 15));
      issue_rd     = 5'($urandom_range(0, 3));
      issue_to_int = $urandom_range(0, 1);
      chk_rs1      = 5'($urandom_range(0, 3));
      chk_rs2      = 5'($urandom_range(0, 3));
      chk_float    = $urandom_range(0, 1);
      ld_wb_valid  = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      fflags_clr   = ($urandom_range(0, 15) == 0);
      fpu_result   = $urandom;
      fpu_flags    = 5'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
